// File: rtl/seq_divider_32by16.sv
// Sequential radix-2 restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per cycle, valid/ready handshakes on input and output.
module seq_divider_32by16 #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);
    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never drops and its payload never changes until then.

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  divisor_q;
    logic [CW-1:0] count;

    logic [N:0]    trial;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  quo_next;

    // Since rem_q < divisor, a non-negative trial always fits in N bits.
    always_comb begin
        trial    = {rem_q, quo_q[N-1]} - {1'b0, divisor_q};
        rem_next = trial[N] ? {rem_q[N-2:0], quo_q[N-1]} : trial[N-1:0];
        quo_next = {quo_q[N-2:0], ~trial[N]};
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor_q <= divisor;
                        count     <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                        end else if (dividend[2*N-1:N] >= divisor) begin
                            state       <= DONE;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '1;
                        end else begin
                            state       <= RUN;
                            rem_q       <= dividend[2*N-1:N];
                            quo_q       <= dividend[N-1:0];
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= quo_next;
                        remainder <= rem_next;
                    end
                end
                DONE: begin
                    // Exception results enter DONE with out_valid low and raise it
                    // one cycle later, giving them a fixed one-cycle latency.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_divider_32by16.md
Name: seq_divider_32by16

Overview:
Sequential radix-2 restoring divider. It takes a 32-bit dividend and a 16-bit divisor and returns a 16-bit quotient and a 16-bit remainder. It is the inverse of the team's combinational 16x16 array multiplier: it recovers one multiplier operand from a product and the other operand. It is used for result checking and for normalisation paths, with valid/ready handshakes on both input and output.

Parameters:
- N, 16, divisor/quotient/remainder width. Dividend width is 2N. Only N=16 is verified.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  32  numerator
- divisor  input  16  denominator
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- quotient  output  16  result quotient
- remainder  output  16  result remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  quotient does not fit in 16 bits

Behaviour:
- Reset (sampled at a clk edge with rst=1): state=IDLE; out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, iteration count=0. in_ready=1 from the first cycle after reset.
- rst has priority over every other input in every state. Reset mid-RUN abandons the operation and emits no output.
- State IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready at an edge; latch the operands.
  - If divisor==0: go to DONE with div_by_zero=1, overflow=0, quotient=16'hFFFF, remainder=dividend[15:0].
  - Else if dividend[31:16] >= divisor: go to DONE with overflow=1, div_by_zero=0, quotient=16'hFFFF, remainder=16'hFFFF.
  - Else: go to RUN with partial remainder R=dividend[31:16], shift register Q=dividend[15:0], count=0, and both flags cleared.
- State RUN:
  - in_ready=0.
  - Each cycle computes T = {R,Q[15]} - {1'b0,divisor}, using a 17-bit subtract.
  - If T is non-negative: R<=T[15:0] and the new quotient LSB is 1. Otherwise R<={R[14:0],Q[15]} and the LSB is 0.
  - Q shifts left by one with the new quotient bit inserted at bit 0. count increments.
  - After the 16th iteration (count==15 at the edge): go to DONE with quotient=Q and remainder=R.
- State DONE:
  - out_valid=1, in_ready=0. Outputs and flags stay stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready at an edge: go to IDLE and set out_valid=0. quotient, remainder and flags keep their last values.
- Latency:
  - Normal operation: acceptance at edge k gives out_valid=1 after edge k+16.
  - div0 or overflow: out_valid=1 after edge k+1.
  - Minimum spacing between accepts is 18 cycles (normal) or 3 cycles (exception). No accept is possible while in DONE.
- Operand changes on dividend/divisor after acceptance have no effect.
- Arithmetic invariant for every non-exception result: quotient*divisor + remainder == dividend, and remainder < divisor.
- Boundaries:
  - divisor=1 with dividend[31:16]=0 gives quotient=dividend[15:0], remainder=0.
  - A dividend with dividend[31:16]==divisor-1 is legal and does not overflow.

Test Plan:
- Inverse of the multiplier: dividend=32'h06260060, divisor=16'h5678 -> quotient=16'h1234, remainder=0, flags 0, out_valid exactly 16 cycles after the accept edge.
- Remainder and maximum case: dividend=32'h06260065 / 16'h5678 -> q=16'h1234, r=5. Dividend=32'hFFFE0001 / 16'hFFFF -> q=16'hFFFF, r=0.
- Exceptions:
  - dividend=32'h00010000, divisor=1 -> overflow=1, q=16'hFFFF, r=16'hFFFF after one cycle.
  - divisor=0, dividend=32'hABCD1234 -> div_by_zero=1, q=16'hFFFF, r=16'h1234.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and outputs stay stable and in_ready=0. When out_ready=1, the next cycle has in_ready=1.
- Reset mid-RUN: assert rst at iteration 8 -> next cycle out_valid=0 and in_ready=1, no result is emitted. A new operation then completes correctly.
- Randomised: 10k random operand pairs under the no-overflow constraint, checked against the invariant. Include random in_valid/out_ready gaps, and verify in_valid is ignored while busy.
